// File: rtl/key_beep_ctrl.sv
// -----------------------------------------------------------------------------
// key_beep_ctrl
//   Consumer of the debounced-key interface. Tracks the debounced key level,
//   classifies each press as short or long, and plays a square-wave beep
//   pattern on the buzzer: one beep for a short press, two beeps separated by
//   a silent gap for a long press.
//
// Parameters
//   TONE_DIV  half-period of the beep tone, in clk cycles
//   BEEP_CYC  duration of one beep, in clk cycles
//   GAP_CYC   silent gap between the two beeps of a long-press pattern
//   LONG_CYC  hold time at which a press is classified long
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_flag   one-cycle strobe, key_value valid (repeats while level stable)
//   key_value  debounced key level, 0 = pressed, 1 = released
//   beep       buzzer drive, active-high square wave
//   busy       high while a beep pattern is playing (BEEP1, GAP, BEEP2)
//   evt_short  one-cycle pulse on short-press classification
//   evt_long   one-cycle pulse on long-press classification
// -----------------------------------------------------------------------------
module key_beep_ctrl #(
    parameter int unsigned TONE_DIV = 12_500,
    parameter int unsigned BEEP_CYC = 5_000_000,
    parameter int unsigned GAP_CYC  = 5_000_000,
    parameter int unsigned LONG_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic beep,
    output logic busy,
    output logic evt_short,
    output logic evt_long
);

    localparam int unsigned DUR_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int unsigned DUR_W   = (DUR_MAX  > 1) ? $clog2(DUR_MAX)  : 1;
    localparam int unsigned HOLD_W  = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [DUR_W-1:0]  BEEP_LAST = DUR_W'(BEEP_CYC - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HELD,
        S_BEEP1,
        S_GAP,
        S_BEEP2
    } state_t;

    state_t              r_state;
    logic                r_key_level;
    logic                r_dbl;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_beep;
    logic                r_busy;
    logic                r_evt_short;
    logic                r_evt_long;

    state_t              w_state_nxt;
    logic                w_dbl_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [DUR_W-1:0]    w_dur_nxt;
    logic [TONE_W-1:0]   w_tone_nxt;
    logic                w_beep_nxt;
    logic                w_busy_nxt;
    logic                w_evt_short_nxt;
    logic                w_evt_long_nxt;
    logic                w_press;
    logic                w_release;

    // Edges are relative to the tracked level, so repeated strobes carrying
    // an unchanged value never look like a new press or release.
    assign w_press   = key_flag && !key_value &&  r_key_level;
    assign w_release = key_flag &&  key_value && !r_key_level;

    always_comb begin
        w_state_nxt     = r_state;
        w_dbl_nxt       = r_dbl;
        w_hold_nxt      = r_hold_cnt;
        w_dur_nxt       = r_dur_cnt;
        w_tone_nxt      = r_tone_cnt;
        w_beep_nxt      = 1'b0;
        w_evt_short_nxt = 1'b0;
        w_evt_long_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_HELD;
                    w_hold_nxt  = '0;
                end
            end

            S_HELD: begin
                // Release wins over the long threshold when both land in the
                // same cycle, so that case is classified short.
                if (w_release) begin
                    w_state_nxt     = S_BEEP1;
                    w_dbl_nxt       = 1'b0;
                    w_evt_short_nxt = 1'b1;
                    w_hold_nxt      = '0;
                    w_dur_nxt       = '0;
                    w_tone_nxt      = '0;
                    w_beep_nxt      = 1'b1;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt     = S_BEEP1;
                    w_dbl_nxt       = 1'b1;
                    w_evt_long_nxt  = 1'b1;
                    w_hold_nxt      = '0;
                    w_dur_nxt       = '0;
                    w_tone_nxt      = '0;
                    w_beep_nxt      = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            S_BEEP1, S_BEEP2: begin
                if (r_dur_cnt == BEEP_LAST) begin
                    w_dur_nxt   = '0;
                    w_tone_nxt  = '0;
                    w_state_nxt = (r_state == S_BEEP1 && r_dbl) ? S_GAP : S_IDLE;
                end else begin
                    w_dur_nxt = r_dur_cnt + DUR_W'(1);
                    if (r_tone_cnt == TONE_LAST) begin
                        w_tone_nxt = '0;
                        w_beep_nxt = ~r_beep;
                    end else begin
                        w_tone_nxt = r_tone_cnt + TONE_W'(1);
                        w_beep_nxt = r_beep;
                    end
                end
            end

            S_GAP: begin
                if (r_dur_cnt == GAP_LAST) begin
                    w_state_nxt = S_BEEP2;
                    w_dur_nxt   = '0;
                    w_tone_nxt  = '0;
                    w_beep_nxt  = 1'b1;
                end else begin
                    w_dur_nxt = r_dur_cnt + DUR_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_BEEP1) || (w_state_nxt == S_GAP) ||
                     (w_state_nxt == S_BEEP2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_key_level <= 1'b1;
            r_dbl       <= 1'b0;
            r_hold_cnt  <= '0;
            r_dur_cnt   <= '0;
            r_tone_cnt  <= '0;
            r_beep      <= 1'b0;
            r_busy      <= 1'b0;
            r_evt_short <= 1'b0;
            r_evt_long  <= 1'b0;
        end else begin
            if (key_flag) begin
                r_key_level <= key_value;
            end
            r_state     <= w_state_nxt;
            r_dbl       <= w_dbl_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_dur_cnt   <= w_dur_nxt;
            r_tone_cnt  <= w_tone_nxt;
            r_beep      <= w_beep_nxt;
            r_busy      <= w_busy_nxt;
            r_evt_short <= w_evt_short_nxt;
            r_evt_long  <= w_evt_long_nxt;
        end
    end

    assign beep      = r_beep;
    assign busy      = r_busy;
    assign evt_short = r_evt_short;
    assign evt_long  = r_evt_long;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_beep_ctrl
//   Self-checking bench for key_beep_ctrl with small timing parameters.
//   A reference model predicts outputs from press/release timing and the
//   beep pattern shape; a table of press scenarios, hand-written sequences
//   and a random phase drive the design.
// -----------------------------------------------------------------------------
module tb_key_beep_ctrl;

    localparam int TD = 4;
    localparam int BC = 32;
    localparam int GC = 16;
    localparam int LC = 100;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic key_flag  = 1'b0;
    logic key_value = 1'b1;
    logic beep;
    logic busy;
    logic evt_short;
    logic evt_long;

    always #5 clk = ~clk;

    key_beep_ctrl #(
        .TONE_DIV(TD),
        .BEEP_CYC(BC),
        .GAP_CYC (GC),
        .LONG_CYC(LC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_flag (key_flag),
        .key_value(key_value),
        .beep     (beep),
        .busy     (busy),
        .evt_short(evt_short),
        .evt_long (evt_long)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time-stamp based (cycle index of press and of pattern start)
    int m_cyc;
    bit m_level;
    bit m_holding;
    int m_press_at;
    int m_pat_start;
    bit m_dbl;
    bit m_evs;
    bit m_evl;

    int obs_s;
    int obs_l;
    int obs_busy;

    typedef struct {
        int hold;
        int strobe;
        int exp_short;
        int exp_long;
        int exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pat_len(input bit d);
        return d ? (2 * BC + GC) : BC;
    endfunction

    task automatic model_reset();
        m_cyc       = 0;
        m_level     = 1'b1;
        m_holding   = 1'b0;
        m_press_at  = 0;
        m_pat_start = -1000;
        m_dbl       = 1'b0;
        m_evs       = 1'b0;
        m_evl       = 1'b0;
    endtask

    task automatic model_step(input bit f, input bit v);
        bit press;
        bit rel;
        m_cyc++;
        press = f && !v && m_level;
        rel   = f && v && !m_level;
        m_evs = 1'b0;
        m_evl = 1'b0;
        if (m_cyc > m_pat_start && m_cyc <= m_pat_start + pat_len(m_dbl)) begin
            // pattern in progress: key edges are not acted on
        end else if (m_holding) begin
            if (rel) begin
                m_evs = 1'b1;
                m_holding = 1'b0;
                m_pat_start = m_cyc;
                m_dbl = 1'b0;
            end else if (m_cyc - 1 - m_press_at == LC - 1) begin
                m_evl = 1'b1;
                m_holding = 1'b0;
                m_pat_start = m_cyc;
                m_dbl = 1'b1;
            end
        end else if (press) begin
            m_holding  = 1'b1;
            m_press_at = m_cyc;
        end
        if (f) m_level = v;
    endtask

    function automatic logic [3:0] model_out();
        int o;
        bit bz;
        bit b;
        o  = m_cyc - m_pat_start;
        bz = (o >= 0) && (o < pat_len(m_dbl));
        b  = 1'b0;
        if (bz) begin
            if (o < BC)            b = ((o / TD) % 2) == 0;
            else if (o >= BC + GC) b = (((o - BC - GC) / TD) % 2) == 0;
        end
        return {b, bz, m_evs, m_evl};
    endfunction

    task automatic tick(input bit f, input bit v);
        @(negedge clk);
        key_flag  = f;
        key_value = v;
        @(posedge clk);
        model_step(f, v);
        #1;
        chk($sformatf("out[beep,busy,short,long]@%0d", m_cyc),
            int'({beep, busy, evt_short, evt_long}), int'(model_out()));
        obs_s    += int'(evt_short);
        obs_l    += int'(evt_long);
        obs_busy += int'(busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic clr_obs();
        obs_s = 0;
        obs_l = 0;
        obs_busy = 0;
    endtask

    initial begin
        vecs[0] = '{hold: 30,  strobe: 0,  exp_short: 1, exp_long: 0, exp_busy: 32};
        vecs[1] = '{hold: 1,   strobe: 0,  exp_short: 1, exp_long: 0, exp_busy: 32};
        vecs[2] = '{hold: 99,  strobe: 0,  exp_short: 1, exp_long: 0, exp_busy: 32};
        vecs[3] = '{hold: 100, strobe: 0,  exp_short: 1, exp_long: 0, exp_busy: 32};
        vecs[4] = '{hold: 101, strobe: 0,  exp_short: 0, exp_long: 1, exp_busy: 80};
        vecs[5] = '{hold: 150, strobe: 0,  exp_short: 0, exp_long: 1, exp_busy: 80};
        vecs[6] = '{hold: 60,  strobe: 10, exp_short: 1, exp_long: 0, exp_busy: 32};
        vecs[7] = '{hold: 150, strobe: 10, exp_short: 0, exp_long: 1, exp_busy: 80};

        model_reset();
        clr_obs();

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({beep, busy, evt_short, evt_long}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // table of press scenarios
        for (int t = 0; t < 8; t++) begin
            clr_obs();
            tick(1'b1, 1'b0);
            for (int k = 1; k < vecs[t].hold; k++) begin
                if (vecs[t].strobe != 0 && (k % vecs[t].strobe) == 0) tick(1'b1, 1'b0);
                else tick(1'b0, 1'($urandom_range(0, 1)));
            end
            tick(1'b1, 1'b1);
            idle(130);
            chk($sformatf("vec%0d_short_count", t), obs_s, vecs[t].exp_short);
            chk($sformatf("vec%0d_long_count", t), obs_l, vecs[t].exp_long);
            chk($sformatf("vec%0d_busy_cycles", t), obs_busy, vecs[t].exp_busy);
        end

        // press and release during the GAP of a long pattern
        clr_obs();
        tick(1'b1, 1'b0);
        idle(100);
        tick(1'b1, 1'b1);
        idle(34);
        chk("gap_busy_before_press", int'(busy), 1);
        chk("gap_beep_silent", int'(beep), 0);
        tick(1'b1, 1'b0);
        idle(5);
        tick(1'b1, 1'b1);
        idle(110);
        chk("gap_short_count", obs_s, 0);
        chk("gap_long_count", obs_l, 1);
        chk("gap_busy_cycles", obs_busy, 80);
        clr_obs();
        tick(1'b1, 1'b0);
        idle(20);
        tick(1'b1, 1'b1);
        idle(40);
        chk("after_gap_short_count", obs_s, 1);
        chk("after_gap_busy_cycles", obs_busy, 32);

        // key still held at end of pattern: no new press until release+press
        clr_obs();
        tick(1'b1, 1'b0);
        idle(100);
        tick(1'b1, 1'b1);
        idle(10);
        tick(1'b1, 1'b0);
        idle(80);
        tick(1'b1, 1'b0);
        idle(20);
        chk("held_over_no_new_event", obs_s + obs_l, 1);
        tick(1'b1, 1'b1);
        idle(10);
        chk("held_over_release_ignored", obs_s, 0);
        tick(1'b1, 1'b0);
        idle(10);
        tick(1'b1, 1'b1);
        idle(40);
        chk("held_over_fresh_short", obs_s, 1);

        // asynchronous reset in the middle of BEEP2
        tick(1'b1, 1'b0);
        idle(159);
        chk("beep2_busy_before_reset", int'(busy), 1);
        chk("beep2_beep_before_reset", int'(beep), 1);
        #2;
        rst_n = 1'b0;
        key_flag = 1'b0;
        #1;
        chk("async_reset_outputs", int'({beep, busy, evt_short, evt_long}), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_outputs", int'({beep, busy, evt_short, evt_long}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clr_obs();
        tick(1'b1, 1'b0);
        idle(20);
        tick(1'b1, 1'b1);
        idle(40);
        chk("post_reset_short_count", obs_s, 1);
        chk("post_reset_busy_cycles", obs_busy, 32);

        // random key activity against the model
        begin
            bit lvl;
            bit f;
            lvl = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 59) == 0) lvl = ~lvl;
                f = ($urandom_range(0, 3) == 0);
                tick(f, f ? lvl : 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
